// File: rtl/fetch_decode_stage.sv
// Instruction fetch and IF/ID pipeline register for the MiniMIPS core.
// Drives a synchronous-read instruction memory and registers the decoded fields of each returned word.
module fetch_decode_stage #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    output logic [PC_W-1:0] out_pc,
    output logic [3:0]      opcode,
    output logic [2:0]      rs,
    output logic [2:0]      rt,
    output logic [2:0]      rd,
    output logic [2:0]      funct,
    output logic [5:0]      imm6,
    output logic            is_rtype
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [PC_W-1:0] fetch_pc_reg;
    logic [PC_W-1:0] req_pc_reg;
    logic            req_valid_reg;

    // imem_rdata always reflects mem[req_pc_reg]; presenting req_pc_reg during a stall re-reads it.
    always_comb begin
        imem_addr = fetch_pc_reg;
        if (reset)
            imem_addr = RESET_PC;
        else if (redirect_valid)
            imem_addr = redirect_pc;
        else if (stall)
            imem_addr = req_pc_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg  <= RESET_PC;
            req_pc_reg    <= RESET_PC;
            req_valid_reg <= 1'b0;
            out_valid     <= 1'b0;
            out_pc        <= '0;
            opcode        <= '0;
            rs            <= '0;
            rt            <= '0;
            rd            <= '0;
            funct         <= '0;
            imm6          <= '0;
            is_rtype      <= 1'b0;
        end else if (redirect_valid) begin
            // Flush the wrong-path word; decoded fields hold but are marked invalid.
            req_pc_reg    <= redirect_pc;
            req_valid_reg <= 1'b1;
            fetch_pc_reg  <= redirect_pc + PC_ONE;
            out_valid     <= 1'b0;
        end else if (!stall) begin
            out_valid     <= req_valid_reg;
            out_pc        <= req_pc_reg;
            opcode        <= imem_rdata[15:12];
            rs            <= imem_rdata[11:9];
            rt            <= imem_rdata[8:6];
            rd            <= imem_rdata[5:3];
            funct         <= imem_rdata[2:0];
            imm6          <= imem_rdata[5:0];
            is_rtype      <= (imem_rdata[15:12] == 4'b0000);
            req_pc_reg    <= fetch_pc_reg;
            req_valid_reg <= 1'b1;
            fetch_pc_reg  <= fetch_pc_reg + PC_ONE;
        end
    end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: a 32-bit PC instance for the main scenarios
// and a 4-bit PC instance for address wrap and mid-stream reset.
module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 32-bit PC instance
    logic        reset, stall, redirect_valid;
    logic [31:0] redirect_pc, imem_addr, out_pc;
    logic [15:0] imem_rdata;
    logic        out_valid, is_rtype;
    logic [3:0]  opcode;
    logic [2:0]  rs, rt, rd, funct;
    logic [5:0]  imm6;
    logic [15:0] mem [0:255];

    fetch_decode_stage #(.PC_W(32), .RESET_PC(32'd0)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .funct(funct), .imm6(imm6), .is_rtype(is_rtype)
    );

    always @(posedge clk) imem_rdata <= mem[imem_addr[7:0]];

    // 4-bit PC instance
    logic        reset2;
    logic [3:0]  imem_addr2, out_pc2;
    logic [15:0] imem_rdata2;
    logic        out_valid2, is_rtype2;
    logic [3:0]  opcode2;
    logic [2:0]  rs2, rt2, rd2, funct2;
    logic [5:0]  imm62;
    logic [15:0] mem2 [0:15];

    fetch_decode_stage #(.PC_W(4), .RESET_PC(4'd0)) dut2 (
        .clk(clk), .reset(reset2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(4'd0),
        .out_valid(out_valid2), .out_pc(out_pc2), .opcode(opcode2), .rs(rs2), .rt(rt2),
        .rd(rd2), .funct(funct2), .imm6(imm62), .is_rtype(is_rtype2)
    );

    always @(posedge clk) imem_rdata2 <= mem2[imem_addr2];

    task automatic step();
        @(posedge clk);
        #1;
        $display("[TB] t=%0t valid=%0b pc=%0d op=%0h addr=%0d | valid2=%0b pc2=%0d",
                 $time, out_valid, out_pc, opcode, imem_addr, out_valid2, out_pc2);
    endtask

    task automatic test_reset();
        reset = 1'b1; reset2 = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) step();
        tests++; if (imem_addr !== 32'd0) begin fails++; $display("FAIL reset_addr got=%0d exp=0", imem_addr); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        tests++; if ({out_pc, opcode, rs, rt, rd, funct, imm6, is_rtype} !== '0) begin
            fails++; $display("FAIL reset_fields got pc=%0d op=%0h rs=%0d rt=%0d rd=%0d f=%0d imm=%0h rt=%0b exp all 0",
                              out_pc, opcode, rs, rt, rd, funct, imm6, is_rtype);
        end
        reset = 1'b0;
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL first_edge_valid got=%0b exp=0", out_valid); end
        tests++; if (imem_addr !== 32'd1) begin fails++; $display("FAIL first_edge_addr got=%0d exp=1", imem_addr); end
        step();
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || opcode !== 4'd1) begin
            fails++; $display("FAIL first_instr got valid=%0b pc=%0d op=%0h exp valid=1 pc=0 op=1", out_valid, out_pc, opcode);
        end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 4; i++) begin
            step();
            tests++; if (out_valid !== 1'b1 || out_pc !== 32'(i)) begin
                fails++; $display("FAIL stream_pc got valid=%0b pc=%0d exp valid=1 pc=%0d", out_valid, out_pc, i);
            end
            if (i == 3) begin
                tests++; if ({opcode, rs, rt, rd, funct, imm6, is_rtype} !== {4'd0, 3'd5, 3'd1, 3'd3, 3'd3, 6'h1B, 1'b1}) begin
                    fails++; $display("FAIL rtype_decode got op=%0h rs=%0d rt=%0d rd=%0d f=%0d imm=%0h r=%0b exp 0/5/1/3/3/1b/1",
                                      opcode, rs, rt, rd, funct, imm6, is_rtype);
                end
            end else begin
                tests++; if (opcode !== 4'd1 || funct !== 3'(i) || is_rtype !== 1'b0) begin
                    fails++; $display("FAIL stream_decode got op=%0h f=%0d r=%0b exp op=1 f=%0d r=0", opcode, funct, is_rtype, i);
                end
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        tests++; if (imem_addr !== 32'd5) begin fails++; $display("FAIL stall_addr got=%0d exp=5", imem_addr); end
        repeat (3) begin
            step();
            tests++; if (out_valid !== 1'b1 || out_pc !== 32'd4 || funct !== 3'd4 || imem_addr !== 32'd5) begin
                fails++; $display("FAIL stall_hold got valid=%0b pc=%0d f=%0d addr=%0d exp 1/4/4/5", out_valid, out_pc, funct, imem_addr);
            end
        end
        stall = 1'b0;
        for (int p = 5; p <= 6; p++) begin
            step();
            tests++; if (out_valid !== 1'b1 || out_pc !== 32'(p) || funct !== 3'(p)) begin
                fails++; $display("FAIL stall_release got valid=%0b pc=%0d f=%0d exp 1/%0d/%0d", out_valid, out_pc, funct, p, p);
            end
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'd40;
        #1;
        tests++; if (imem_addr !== 32'd40) begin fails++; $display("FAIL redirect_addr got=%0d exp=40", imem_addr); end
        step();
        redirect_valid = 1'b0;
        tests++; if (out_valid !== 1'b0 || out_pc !== 32'd6) begin
            fails++; $display("FAIL redirect_flush got valid=%0b pc=%0d exp valid=0 pc=6", out_valid, out_pc);
        end
        step();
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'd40 || imm6 !== 6'h28) begin
            fails++; $display("FAIL redirect_target got valid=%0b pc=%0d imm=%0h exp 1/40/28", out_valid, out_pc, imm6);
        end
        step();
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'd41) begin
            fails++; $display("FAIL redirect_next got valid=%0b pc=%0d exp 1/41", out_valid, out_pc);
        end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd100;
        #1;
        tests++; if (imem_addr !== 32'd100) begin fails++; $display("FAIL rs_addr got=%0d exp=100", imem_addr); end
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rs_flush got valid=%0b exp=0", out_valid); end
        step();
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'd100 || imm6 !== 6'h24) begin
            fails++; $display("FAIL rs_target got valid=%0b pc=%0d imm=%0h exp 1/100/24", out_valid, out_pc, imm6);
        end
        // Stall while holding a bubble must not create a valid instruction.
        redirect_valid = 1'b1; redirect_pc = 32'd200;
        step();
        redirect_valid = 1'b0; stall = 1'b1;
        repeat (2) begin
            step();
            tests++; if (out_valid !== 1'b0 || imem_addr !== 32'd200) begin
                fails++; $display("FAIL bubble_stall got valid=%0b addr=%0d exp 0/200", out_valid, imem_addr);
            end
        end
        stall = 1'b0;
        step();
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'd200 || rd !== 3'd1 || funct !== 3'd0) begin
            fails++; $display("FAIL bubble_release got valid=%0b pc=%0d rd=%0d f=%0d exp 1/200/1/0", out_valid, out_pc, rd, funct);
        end
        step();
        tests++; if (out_pc !== 32'd201) begin fails++; $display("FAIL bubble_next got pc=%0d exp=201", out_pc); end
    endtask

    task automatic test_wrap_reset();
        reset2 = 1'b0;
        step();
        step();
        tests++; if (out_valid2 !== 1'b1 || out_pc2 !== 4'd0) begin
            fails++; $display("FAIL wrap_start got valid=%0b pc=%0d exp 1/0", out_valid2, out_pc2);
        end
        repeat (13) step();
        for (int j = 0; j < 4; j++) begin
            int e;
            e = (14 + j) % 16;
            step();
            tests++; if (out_valid2 !== 1'b1 || out_pc2 !== 4'(e) || opcode2 !== 4'(e) || is_rtype2 !== (e == 0)) begin
                fails++; $display("FAIL wrap_seq got valid=%0b pc=%0d op=%0h r=%0b exp pc=%0d", out_valid2, out_pc2, opcode2, is_rtype2, e);
            end
        end
        reset2 = 1'b1;
        #1;
        tests++; if (imem_addr2 !== 4'd0) begin fails++; $display("FAIL midreset_addr got=%0d exp=0", imem_addr2); end
        step();
        reset2 = 1'b0;
        tests++; if (out_valid2 !== 1'b0 || out_pc2 !== 4'd0 || opcode2 !== 4'd0) begin
            fails++; $display("FAIL midreset_clear got valid=%0b pc=%0d op=%0h exp 0/0/0", out_valid2, out_pc2, opcode2);
        end
        step();
        tests++; if (out_valid2 !== 1'b0) begin fails++; $display("FAIL midreset_edge1 got valid=%0b exp=0", out_valid2); end
        step();
        tests++; if (out_valid2 !== 1'b1 || out_pc2 !== 4'd0) begin
            fails++; $display("FAIL midreset_restart got valid=%0b pc=%0d exp 1/0", out_valid2, out_pc2);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[3] = 16'h0A5B;
        for (int i = 0; i < 16; i++) mem2[i] = 16'(i * 16'h1001);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
